// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - core/io clock select sequencer
// Gates downstream clocks, checks io_clock activity, then flips the mux select.
module clock_switch_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int WINDOW_CYCLES = 64,
  parameter int MIN_EDGES     = 4,
  parameter int CNT_W         = 8
) (
  input  logic             core_clock,
  input  logic             core_reset_n,
  input  logic             io_clock,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  output logic             sel_out,
  output logic             gate_en,
  output logic             busy,
  output logic             done_pulse,
  output logic             fault,
  output logic [CNT_W-1:0] edge_count
);

  localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    CHECK  = 3'd2,
    SWITCH = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TW-1:0]     timer;
  logic [2:0]        io_sync;
  logic              io_rise;
  logic              req_sel_q;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_sum;
  logic              edges_ok;
  logic              settle_end;
  logic              window_end;
  logic              accept;

  // io_sync[0] = s1, [1] = s2, [2] = s3; a rise is s2 & ~s3
  assign io_rise    = io_sync[1] & ~io_sync[2];
  assign accept     = req_valid & req_ready;
  assign settle_end = (timer == TW'(SETTLE_CYCLES - 1));
  assign window_end = (timer == TW'(WINDOW_CYCLES - 1));

  always_comb begin
    edge_sum = edge_cnt;
    if (io_rise && (edge_cnt != {CNT_W{1'b1}}))
      edge_sum = edge_cnt + CNT_W'(1);
  end

  assign edges_ok = (edge_sum >= CNT_W'(MIN_EDGES));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (req_sel == sel_out) ? DONE : DRAIN;
      DRAIN:   if (settle_end) state_next = req_sel_q ? CHECK : SWITCH;
      CHECK:   if (window_end) state_next = edges_ok ? SWITCH : DONE;
      SWITCH:  state_next = HOLD;
      HOLD:    if (settle_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge core_clock or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      io_sync    <= '0;
      req_sel_q  <= 1'b0;
      edge_cnt   <= '0;
      edge_count <= '0;
      sel_out    <= 1'b0;
      gate_en    <= 1'b1;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      done_pulse <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state   <= state_next;
      io_sync <= {io_sync[1:0], io_clock};

      if ((state_next != state) || (state == IDLE))
        timer <= '0;
      else
        timer <= timer + TW'(1);

      if ((state == IDLE) && accept) begin
        req_sel_q <= req_sel;
        fault     <= 1'b0;
      end

      // Counter only runs inside the window, so it restarts from zero on every CHECK entry
      if (state == CHECK) begin
        edge_cnt <= edge_sum;
        if (window_end) begin
          edge_count <= edge_sum;
          if (!edges_ok)
            fault <= 1'b1;
        end
      end else begin
        edge_cnt <= '0;
      end

      if (state == SWITCH)
        sel_out <= req_sel_q;

      gate_en    <= !((state == DRAIN) || (state == CHECK) ||
                      (state == SWITCH) || (state == HOLD));
      done_pulse <= (state == DONE);
      busy       <= (state_next != IDLE);
      req_ready  <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - directed bench for clock_switch_ctrl
// Instance a uses default parameters, instance b uses MIN_EDGES=9.
module tb_clock_switch_ctrl;

  logic       core_clock = 1'b0;
  logic       core_reset_n = 1'b0;
  logic       io_clock = 1'b0;
  logic       io_run = 1'b0;
  logic       req_valid_a = 1'b0;
  logic       req_valid_b = 1'b0;
  logic       req_sel = 1'b0;
  logic       sel_dut = 1'b0;

  logic       req_ready_a, sel_out_a, gate_en_a, busy_a, done_pulse_a, fault_a;
  logic [7:0] edge_count_a;
  logic       req_ready_b, sel_out_b, gate_en_b, busy_b, done_pulse_b, fault_b;
  logic [7:0] edge_count_b;

  logic       req_ready, sel_out, gate_en, busy, done_pulse, fault;
  logic [7:0] edge_count;

  int n_assert = 0;
  int n_fail   = 0;

  clock_switch_ctrl dut_a (
    .core_clock   (core_clock),
    .core_reset_n (core_reset_n),
    .io_clock     (io_clock),
    .req_valid    (req_valid_a),
    .req_sel      (req_sel),
    .req_ready    (req_ready_a),
    .sel_out      (sel_out_a),
    .gate_en      (gate_en_a),
    .busy         (busy_a),
    .done_pulse   (done_pulse_a),
    .fault        (fault_a),
    .edge_count   (edge_count_a)
  );

  clock_switch_ctrl #(.MIN_EDGES(9)) dut_b (
    .core_clock   (core_clock),
    .core_reset_n (core_reset_n),
    .io_clock     (io_clock),
    .req_valid    (req_valid_b),
    .req_sel      (req_sel),
    .req_ready    (req_ready_b),
    .sel_out      (sel_out_b),
    .gate_en      (gate_en_b),
    .busy         (busy_b),
    .done_pulse   (done_pulse_b),
    .fault        (fault_b),
    .edge_count   (edge_count_b)
  );

  always #5 core_clock = ~core_clock;
  // io_clock at core/8, edges well away from core posedges
  always #40 io_clock = io_run ? ~io_clock : 1'b0;

  always_comb begin
    if (sel_dut) begin
      req_ready = req_ready_b; sel_out = sel_out_b; gate_en = gate_en_b;
      busy = busy_b; done_pulse = done_pulse_b; fault = fault_b; edge_count = edge_count_b;
    end else begin
      req_ready = req_ready_a; sel_out = sel_out_a; gate_en = gate_en_a;
      busy = busy_a; done_pulse = done_pulse_a; fault = fault_a; edge_count = edge_count_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clock);
    #1;
  endtask

  task automatic drive_valid(input logic v);
    if (sel_dut) req_valid_b = v;
    else         req_valid_a = v;
  endtask

  // Accept at E0; afterwards flip req_sel to show it is captured, not followed
  task automatic start(input logic s);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_sel = s;
    drive_valid(1'b1);
    tick();
    drive_valid(1'b0);
    req_sel = ~s;
    chk("busy_at_e0", 32'(busy), 32'd1);
    chk("ready_low_at_e0", 32'(req_ready), 32'd0);
  endtask

  task automatic watch(input int n, input int glo_first, input int glo_last,
                       input int done_at, input int sel_at,
                       input logic sel_before, input logic sel_after,
                       input int pulse_a, input int pulse_b);
    for (int i = 1; i <= n; i++) begin
      if ((i == pulse_a) || (i == pulse_b)) begin
        chk("ready_low_while_busy", 32'(req_ready), 32'd0);
        drive_valid(1'b1);
      end
      tick();
      drive_valid(1'b0);
      chk($sformatf("gate_en_e%0d", i), 32'(gate_en),
          32'((i >= glo_first && i <= glo_last) ? 1'b0 : 1'b1));
      chk($sformatf("done_e%0d", i), 32'(done_pulse), 32'(i == done_at));
      chk($sformatf("sel_e%0d", i), 32'(sel_out), 32'((i >= sel_at) ? sel_after : sel_before));
      chk($sformatf("excl_e%0d", i), 32'(busy ^ req_ready), 32'd1);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_sel_out", 32'(sel_out), 32'd0);
    chk("rst_gate_en", 32'(gate_en), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_edge_count", 32'(edge_count), 32'd0);
    core_reset_n = 1'b1;
    tick();

    // 1: same source, no gating, done at E1
    start(1'b0);
    watch(3, 0, -1, 1, 99, 1'b0, 1'b0, 0, 0);
    chk("t1_fault", 32'(fault), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // 3: io_clock dead -> fault, no select change, done at E73
    io_run = 1'b0;
    repeat (10) tick();
    start(1'b1);
    watch(75, 1, 72, 73, 999, 1'b0, 1'b0, 0, 0);
    chk("t3_edge_count", 32'(edge_count), 32'd0);
    chk("t3_fault", 32'(fault), 32'd1);

    // 2: io_clock = core/8 -> 8 edges, sel_out=1 from E73, done at E82
    io_run = 1'b1;
    repeat (20) tick();
    start(1'b1);
    chk("t2_fault_cleared", 32'(fault), 32'd0);
    watch(84, 1, 81, 82, 73, 1'b0, 1'b1, 0, 0);
    chk("t2_edge_count", 32'(edge_count), 32'd8);
    chk("t2_fault", 32'(fault), 32'd0);

    // 4: back to core, ignored strobes at E5 and E10, done at E18
    start(1'b0);
    watch(20, 1, 17, 18, 9, 1'b1, 1'b0, 5, 10);
    repeat (3) tick();
    chk("t4_not_queued_busy", 32'(busy), 32'd0);
    chk("t4_not_queued_sel", 32'(sel_out), 32'd0);

    // 5: reset in the middle of an io request
    start(1'b1);
    repeat (40) tick();
    chk("t5_gated_before_rst", 32'(gate_en), 32'd0);
    chk("t5_busy_before_rst", 32'(busy), 32'd1);
    #1;
    core_reset_n = 1'b0;
    #1;
    chk("t5_rst_sel", 32'(sel_out), 32'd0);
    chk("t5_rst_gate", 32'(gate_en), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd1);
    chk("t5_rst_no_done", 32'(done_pulse), 32'd0);
    tick();
    core_reset_n = 1'b1;
    tick();
    start(1'b1);
    watch(84, 1, 81, 82, 73, 1'b0, 1'b1, 0, 0);
    chk("t5_edge_count", 32'(edge_count), 32'd8);

    // 6: MIN_EDGES=9 instance sees only 8 edges -> fault, cleared at next accept
    sel_dut = 1'b1;
    #1;
    start(1'b1);
    watch(75, 1, 72, 73, 999, 1'b0, 1'b0, 0, 0);
    chk("t6_edge_count", 32'(edge_count), 32'd8);
    chk("t6_fault", 32'(fault), 32'd1);
    start(1'b0);
    chk("t6_fault_cleared_e0", 32'(fault), 32'd0);
    tick();
    chk("t6_done_e1", 32'(done_pulse), 32'd1);
    chk("t6_gate_e1", 32'(gate_en), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
